// File: rtl/sp_spi_engine.sv
// Byte-wide SPI master, mode 0, MSB first, for the service processor SD card pins.
// One byte is shifted out and one is captured per request; chip select is handled elsewhere.
module sp_spi_engine #(
  parameter int DIV_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [0:7]           tx_data,
  output logic                 rx_valid,
  output logic [0:7]           rx_data,
  output logic                 busy,
  output logic                 sdcard_sck,
  output logic                 sdcard_mosi,
  input  logic                 sdcard_miso
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   hc;
  logic [3:0]             hp;
  logic [0:7]             tx_shift;
  logic [0:7]             rx_shift;
  logic [SYNC_STAGES-1:0] miso_sync;
  logic                   miso_s;
  logic                   accept;

  assign miso_s = miso_sync[SYNC_STAGES-1];
  assign accept = tx_valid && tx_ready;

  // Flops idle high so a floating or released MISO line reads as 1s.
  always_ff @(posedge clk) begin
    if (reset) begin
      miso_sync <= '1;
    end else begin
      miso_sync[0] <= sdcard_miso;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        miso_sync[i] <= miso_sync[i-1];
      end
    end
  end

  // hp counts the 16 SCK half-periods; its LSB is the SCK level.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      sdcard_sck  <= 1'b0;
      sdcard_mosi <= 1'b1;
      div_q       <= '0;
      hc          <= '0;
      hp          <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          sdcard_sck  <= 1'b0;
          sdcard_mosi <= 1'b1;
          state       <= IDLE;
          if (accept) begin
            tx_shift    <= tx_data;
            div_q       <= div_i;
            hc          <= '0;
            hp          <= '0;
            sdcard_mosi <= tx_data[0];
            tx_ready    <= 1'b0;
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (hc == div_q) begin
            hc <= '0;
            hp <= hp + 4'd1;
            if (!hp[0]) begin
              rx_shift   <= {rx_shift[1:7], miso_s};
              sdcard_sck <= 1'b1;
            end else if (hp == 4'd15) begin
              state       <= DONE;
              rx_valid    <= 1'b1;
              rx_data     <= rx_shift;
              sdcard_sck  <= 1'b0;
              sdcard_mosi <= 1'b1;
              tx_ready    <= 1'b1;
              busy        <= 1'b0;
            end else begin
              tx_shift    <= {tx_shift[1:7], 1'b0};
              sdcard_mosi <= tx_shift[1];
              sdcard_sck  <= 1'b0;
            end
          end else begin
            hc <= hc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_spi_engine.sv
// Randomised bench for sp_spi_engine: records every cycle of the pins and compares
// each transfer against timing rules derived from the divider and the byte sent.
module tb_sp_spi_engine;

  localparam int SYNC = 2;
  localparam int HMAX = 16384;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] div_i;
  logic       tx_valid;
  logic       tx_ready;
  logic [0:7] tx_data;
  logic       rx_valid;
  logic [0:7] rx_data;
  logic       busy;
  logic       sdcard_sck;
  logic       sdcard_mosi;
  logic       sdcard_miso;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  bit         sck_h  [HMAX];
  bit         mosi_h [HMAX];
  bit         miso_h [HMAX];
  bit         rxv_h  [HMAX];
  bit         rdy_h  [HMAX];
  logic [0:7] rxd_h  [HMAX];

  bit         loopback = 1'b1;
  logic [0:7] slave_byte = 8'hFF;
  int         fall_cnt = 0;
  int         fall_base = 0;
  bit         prev_sck = 1'b0;
  logic       miso_drv = 1'b1;

  assign sdcard_miso = miso_drv;

  sp_spi_engine #(.DIV_WIDTH(8), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .div_i(div_i), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .sdcard_sck(sdcard_sck), .sdcard_mosi(sdcard_mosi), .sdcard_miso(sdcard_miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: presents its byte MSB first and advances on each SCK falling edge.
  always @(negedge clk) begin
    int idx;
    if (prev_sck && !sdcard_sck) fall_cnt++;
    prev_sck = sdcard_sck;
    idx = fall_cnt - fall_base;
    if (loopback) miso_drv = sdcard_mosi;
    else miso_drv = (idx >= 0 && idx < 8) ? slave_byte[idx] : 1'b1;
    if (cyc < HMAX) begin
      sck_h[cyc]  = sdcard_sck;
      mosi_h[cyc] = sdcard_mosi;
      miso_h[cyc] = miso_drv;
      rxv_h[cyc]  = rx_valid;
      rdy_h[cyc]  = tx_ready;
      rxd_h[cyc]  = rx_data;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) tick();
  endtask

  task automatic waitReady(input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) checkOutput("ready timeout", 32'd0, 32'd1);
  endtask

  // Issues one byte from an idle engine; t is the cycle in which it is accepted.
  task automatic applyStimulus(input logic [0:7] data, input int d, input logic [0:7] sbyte,
                               input bit lb, output int t);
    waitReady(5000);
    tick();
    waitReady(5000);
    loopback   = lb;
    slave_byte = sbyte;
    fall_base  = fall_cnt;
    tx_data    = data;
    div_i      = 8'(d);
    tx_valid   = 1'b1;
    t          = cyc;
    tick();
    tx_valid   = 1'b0;
  endtask

  // Expected pin waveform: bit k of the byte occupies half-periods 2k and 2k+1,
  // SCK is high in odd half-periods, and MISO is seen SYNC cycles before each rising edge.
  task automatic checkTransfer(input string name, input int t, input int d, input logic [0:7] txb);
    int p, n, c, mb, sb, rises, early;
    logic [0:7] exp_rx;
    p = d + 1;
    n = 16 * p;
    mb = 0; sb = 0; rises = 0; early = 0;
    for (int j = 0; j < n; j++) begin
      c = t + 1 + j;
      if (mosi_h[c] != txb[j / (2 * p)]) mb++;
      if (sck_h[c] != (((j / p) % 2) == 1)) sb++;
      if (sck_h[c] && !sck_h[c-1]) rises++;
      if (rxv_h[c]) early++;
    end
    for (int k = 0; k < 8; k++) exp_rx[k] = miso_h[t + 1 + 2 * k * p + d - SYNC];
    checkOutput({name, " mosi errors"}, mb, 0);
    checkOutput({name, " sck errors"}, sb, 0);
    checkOutput({name, " sck rises"}, rises, 8);
    checkOutput({name, " early rx_valid"}, early, 0);
    checkOutput({name, " rx_valid at T+1+16(d+1)"}, rxv_h[t + n + 1], 1);
    checkOutput({name, " rx_data"}, rxd_h[t + n + 1], exp_rx);
    checkOutput({name, " done pins"}, {sck_h[t + n + 1], mosi_h[t + n + 1]}, 2'b01);
  endtask

  initial begin
    int t, t1, t2, cnt, last, trans;
    logic [0:7] b, s;
    int d;
    bit lb;

    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; div_i = '0;
    repeat (4) tick();
    checkOutput("reset tx_ready", tx_ready, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset rx_valid", rx_valid, 0);
    checkOutput("reset rx_data", rx_data, 8'h00);
    checkOutput("reset sck/mosi", {sdcard_sck, sdcard_mosi}, 2'b01);
    reset = 1'b0;
    repeat (3) tick();

    // Loopback at the fastest rate.
    applyStimulus(8'hA5, 0, 8'hFF, 1'b1, t);
    waitCycle(t + 20);
    checkTransfer("t1", t, 0, 8'hA5);

    // Slave returns 3C while all-ones goes out.
    applyStimulus(8'hFF, 3, 8'h3C, 1'b0, t);
    waitCycle(t + 70);
    checkTransfer("t2", t, 3, 8'hFF);
    checkOutput("t2 rx byte", rxd_h[t + 65], 8'h3C);

    // Back-to-back with tx_valid held; second byte taken in the DONE cycle.
    waitReady(5000);
    tick();
    loopback = 1'b0; slave_byte = 8'h5A; fall_base = fall_cnt;
    tx_data = 8'h01; div_i = 8'd1; tx_valid = 1'b1; t1 = cyc;
    tick();
    tx_data = 8'h80;
    t2 = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx_ready) begin
        t2 = cyc;
        break;
      end
    end
    tick();
    tx_valid = 1'b0;
    checkOutput("t3 second accept cycle", t2 - t1, 33);
    if (t2 < 0) t2 = t1 + 33;
    waitCycle(t2 + 40);
    checkTransfer("t3a", t1, 1, 8'h01);
    checkTransfer("t3b", t2, 1, 8'h80);
    checkOutput("t3 rx_valid count", rxv_h[t1 + 33] + rxv_h[t2 + 33], 2);

    // Reset in the middle of a byte discards it.
    applyStimulus(8'h33, 2, 8'h96, 1'b0, t);
    waitCycle(t + 55);
    checkOutput("t4 pre rx byte", rxd_h[t + 49], 8'h96);
    applyStimulus(8'hC7, 2, 8'h0F, 1'b0, t);
    waitCycle(t + 1 + 9 * 3);
    reset = 1'b1;
    tick();
    checkOutput("t4 sck/mosi", {sdcard_sck, sdcard_mosi}, 2'b01);
    checkOutput("t4 tx_ready", tx_ready, 1);
    checkOutput("t4 busy", busy, 0);
    checkOutput("t4 rx_data", rx_data, 8'h00);
    reset = 1'b0;
    last = cyc;
    waitCycle(last + 80);
    cnt = 0;
    for (int c = t + 1; c < last + 80; c++) if (rxv_h[c]) cnt++;
    checkOutput("t4 rx_valid after reset", cnt, 0);

    // Divider and data changes mid-byte are ignored.
    applyStimulus(8'hC3, 2, 8'hE1, 1'b0, t);
    waitCycle(t + 10);
    div_i = 8'd7; tx_data = 8'h0F; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    waitCycle(t + 60);
    checkTransfer("t5", t, 2, 8'hC3);
    cnt = 0;
    for (int c = t + 50; c < t + 58; c++) if (!rdy_h[c] || rxv_h[c]) cnt++;
    checkOutput("t5 no second transfer", cnt, 0);

    // Slowest divider: 256-cycle half periods.
    applyStimulus(8'h55, 255, 8'hB4, 1'b0, t);
    waitCycle(t + 4100);
    checkTransfer("t6", t, 255, 8'h55);
    checkOutput("t6 rx byte", rxd_h[t + 4097], 8'hB4);
    last = t + 1; cnt = 0; trans = 0;
    for (int c = t + 2; c <= t + 4097; c++) begin
      if (sck_h[c] != sck_h[c-1]) begin
        if (c - last != 256) cnt++;
        last = c;
        trans++;
      end
    end
    checkOutput("t6 edge spacing errors", cnt, 0);
    checkOutput("t6 edge count", trans, 16);

    // Random bytes, dividers and MISO sources.
    for (int r = 0; r < 8; r++) begin
      b  = 8'($urandom);
      s  = 8'($urandom);
      d  = $urandom_range(0, 4);
      lb = 1'($urandom);
      applyStimulus(b, d, s, lb, t);
      waitCycle(t + 16 * (d + 1) + 4);
      checkTransfer($sformatf("rand%0d", r), t, d, b);
      if (d >= SYNC) checkOutput($sformatf("rand%0d rx byte", r), rxd_h[t + 16 * (d + 1) + 1], lb ? b : s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
